// File: rtl/instr_decode.sv
// RV32I decode stage: one elastic pipeline register that splits an instruction word into
// register-select fields, immediate and format code, and counts illegal encodings.
module instr_decode #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic             rs1_en,
    output logic             rs2_en,
    output logic             rd_we,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [2:0]       fmt,
    output logic [XLEN-1:0]  out_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtSys = 3'd6,
        FmtIll = 3'd7
    } fmt_e;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpFence  = 7'b0001111;

    localparam logic [CNT_W-1:0] CntMax = '1;

    // Combinational decode of the incoming word
    fmt_e             dec_fmt;
    logic             dec_illegal;
    logic             dec_rs1_en;
    logic             dec_rs2_en;
    logic             dec_rd_we;
    logic [4:0]       dec_rs1_addr;
    logic [4:0]       dec_rs2_addr;
    logic [4:0]       dec_rd_addr;
    logic [31:0]      dec_imm32;
    logic [XLEN-1:0]  dec_imm;

    // Full 7-bit match also rejects words whose low two bits are not 2'b11
    always_comb begin
        dec_fmt = FmtIll;
        case (instr[6:0])
            OpReg:                   dec_fmt = FmtR;
            OpImm, OpLoad, OpJalr:   dec_fmt = FmtI;
            OpStore:                 dec_fmt = FmtS;
            OpBranch:                dec_fmt = FmtB;
            OpLui, OpAuipc:          dec_fmt = FmtU;
            OpJal:                   dec_fmt = FmtJ;
            OpSystem, OpFence:       dec_fmt = FmtSys;
            default:                 dec_fmt = FmtIll;
        endcase
    end

    always_comb begin
        dec_illegal  = (dec_fmt == FmtIll);
        dec_rs1_en   = dec_fmt inside {FmtR, FmtI, FmtS, FmtB};
        dec_rs2_en   = dec_fmt inside {FmtR, FmtS, FmtB};
        dec_rd_we    = (dec_fmt inside {FmtR, FmtI, FmtU, FmtJ}) && (instr[11:7] != 5'd0);
        dec_rs1_addr = dec_rs1_en ? instr[19:15] : 5'd0;
        dec_rs2_addr = dec_rs2_en ? instr[24:20] : 5'd0;
        dec_rd_addr  = dec_rd_we  ? instr[11:7]  : 5'd0;
    end

    always_comb begin
        dec_imm32 = 32'd0;
        case (dec_fmt)
            FmtI:    dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            FmtS:    dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FmtB:    dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            FmtU:    dec_imm32 = {instr[31:12], 12'd0};
            FmtJ:    dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            default: dec_imm32 = 32'd0;
        endcase
        dec_imm = XLEN'($signed(dec_imm32));
    end

    // Handshake
    logic valid_q;
    logic in_fire;
    logic out_fire;

    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    // Output bundle register
    logic [4:0]       rs1_addr_q;
    logic [4:0]       rs2_addr_q;
    logic [4:0]       rd_addr_q;
    logic             rs1_en_q;
    logic             rs2_en_q;
    logic             rd_we_q;
    logic [XLEN-1:0]  imm_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;
    fmt_e             fmt_q;
    logic [XLEN-1:0]  pc_q;
    logic             illegal_q;
    logic [CNT_W-1:0] illegal_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_addr_q <= 5'd0;
            rs2_addr_q <= 5'd0;
            rd_addr_q  <= 5'd0;
            rs1_en_q   <= 1'b0;
            rs2_en_q   <= 1'b0;
            rd_we_q    <= 1'b0;
            imm_q      <= '0;
            funct3_q   <= 3'd0;
            funct7_q   <= 7'd0;
            fmt_q      <= FmtR;
            pc_q       <= '0;
            illegal_q  <= 1'b0;
        end else if (in_fire) begin
            valid_q    <= 1'b1;
            rs1_addr_q <= dec_rs1_addr;
            rs2_addr_q <= dec_rs2_addr;
            rd_addr_q  <= dec_rd_addr;
            rs1_en_q   <= dec_rs1_en;
            rs2_en_q   <= dec_rs2_en;
            rd_we_q    <= dec_rd_we;
            imm_q      <= dec_imm;
            funct3_q   <= instr[14:12];
            funct7_q   <= instr[31:25];
            fmt_q      <= dec_fmt;
            pc_q       <= in_pc;
            illegal_q  <= dec_illegal;
        end else if (out_fire) begin
            valid_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt_q <= '0;
        end else if (in_fire && dec_illegal && (illegal_cnt_q != CntMax)) begin
            illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid   = valid_q;
    assign rs1_addr    = rs1_addr_q;
    assign rs2_addr    = rs2_addr_q;
    assign rd_addr     = rd_addr_q;
    assign rs1_en      = rs1_en_q;
    assign rs2_en      = rs2_en_q;
    assign rd_we       = rd_we_q;
    assign imm         = imm_q;
    assign funct3      = funct3_q;
    assign funct7      = funct7_q;
    assign fmt         = fmt_q;
    assign out_pc      = pc_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed plus randomised bench for instr_decode: a reference decoder fills a scoreboard
// queue at input fire and the head entry is compared against the output bundle every cycle.
module tb_instr_decode;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_we;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [2:0]  fmt;
        logic [31:0] pc;
        logic        illegal;
    } bundle_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      instr = 32'd0;
    logic [XLEN-1:0]  in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [4:0]       rs1_addr, rs2_addr, rd_addr;
    logic             rs1_en, rs2_en, rd_we;
    logic [XLEN-1:0]  imm;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [2:0]       fmt;
    logic [XLEN-1:0]  out_pc;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    instr_decode #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rs1_en(rs1_en), .rs2_en(rs2_en),
        .rd_we(rd_we), .imm(imm), .funct3(funct3), .funct7(funct7), .fmt(fmt),
        .out_pc(out_pc), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    bundle_t dut_b;
    assign dut_b = {rs1_addr, rs2_addr, rd_addr, rs1_en, rs2_en, rd_we, imm, funct3, funct7,
                    fmt, out_pc, illegal};

    int vectors = 0;
    int miscompares = 0;
    bundle_t exp_q[$];
    logic model_valid = 1'b0;
    logic [CNT_W-1:0] model_cnt = '0;
    logic [31:0] pc_a;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
        bundle_t b;
        b = '0;
        b.funct3 = i[14:12];
        b.funct7 = i[31:25];
        b.pc = pc;
        case (i[6:0])
            7'b0110011: b.fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111: b.fmt = 3'd1;
            7'b0100011: b.fmt = 3'd2;
            7'b1100011: b.fmt = 3'd3;
            7'b0110111, 7'b0010111: b.fmt = 3'd4;
            7'b1101111: b.fmt = 3'd5;
            7'b1110011, 7'b0001111: b.fmt = 3'd6;
            default: begin b.fmt = 3'd7; b.illegal = 1'b1; end
        endcase
        b.rs1_en = (b.fmt <= 3'd3);
        b.rs2_en = (b.fmt == 3'd0) || (b.fmt == 3'd2) || (b.fmt == 3'd3);
        b.rd_we = ((b.fmt == 3'd0) || (b.fmt == 3'd1) || (b.fmt == 3'd4) || (b.fmt == 3'd5))
                  && (i[11:7] != 5'd0);
        if (b.rs1_en) b.rs1_addr = i[19:15];
        if (b.rs2_en) b.rs2_addr = i[24:20];
        if (b.rd_we) b.rd_addr = i[11:7];
        case (b.fmt)
            3'd1: b.imm = {{20{i[31]}}, i[31:20]};
            3'd2: b.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd3: b.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: b.imm = {i[31:12], 12'd0};
            3'd5: b.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: b.imm = 32'd0;
        endcase
        return b;
    endfunction

    // One clock: check in_ready, update the model at the edge, then check outputs.
    task automatic tick();
        logic exp_ready, in_fire, out_fire;
        bundle_t b;
        #1;
        exp_ready = !model_valid || out_ready;
        chk("in_ready", in_ready, exp_ready);
        in_fire = in_valid && exp_ready;
        out_fire = model_valid && out_ready;
        if (out_fire) void'(exp_q.pop_front());
        if (in_fire) begin
            b = model(instr, in_pc);
            exp_q.push_back(b);
            if (b.illegal && model_cnt != CNT_MAX) model_cnt++;
        end
        if (in_fire) model_valid = 1'b1;
        else if (out_fire) model_valid = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            model_valid = 1'b0;
            model_cnt = '0;
        end
        chk("out_valid", out_valid, model_valid);
        chk("illegal_cnt", illegal_cnt, model_cnt);
        if (model_valid) chk("bundle", dut_b, exp_q[0]);
        else if (rst) chk("reset_bundle", dut_b, 128'd0);
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc,
                         input logic ordy);
        in_valid = v;
        instr = i;
        in_pc = pc;
        out_ready = ordy;
    endtask

    logic [6:0] ops [13] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
                             7'b0001111, 7'b0000000, 7'b0110001};

    initial begin
        // Reset with a simultaneous valid input that must be dropped
        rst = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        drive(1'b1, 32'h00500093, 32'h1000, 1'b1);
        tick();
        chk("addi_rs1_en", rs1_en, 1'b1);
        chk("addi_rd", {rd_addr, rd_we}, {5'd1, 1'b1});
        chk("addi_imm", imm, 32'd5);
        chk("addi_fmt", {fmt, rs2_en}, {3'd1, 1'b0});

        drive(1'b1, 32'h002081B3, 32'h1004, 1'b1);
        tick();
        chk("add_regs", {rs1_addr, rs2_addr, rd_addr}, {5'd1, 5'd2, 5'd3});
        chk("add_fmt_imm_f7", {fmt, imm, funct7}, {3'd0, 32'd0, 7'd0});

        drive(1'b1, 32'h0020A423, 32'h1008, 1'b1);
        tick();
        chk("sw_fields", {rs1_addr, rs2_addr, rd_we, rd_addr, funct3},
            {5'd1, 5'd2, 1'b0, 5'd0, 3'd2});
        chk("sw_imm", imm, 32'd8);

        drive(1'b1, 32'hFE000EE3, 32'h100C, 1'b1);
        tick();
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_fmt", fmt, 3'd3);

        // Three back-to-back instructions with a downstream stall on the second cycle
        pc_a = 32'h2000;
        drive(1'b1, 32'h00A00113, pc_a, 1'b1);
        tick();
        drive(1'b1, 32'h00B00193, 32'h2004, 1'b0);
        tick();
        chk("stall_hold_pc", out_pc, pc_a);
        chk("stall_hold_imm", imm, 32'd10);
        drive(1'b1, 32'h00B00193, 32'h2004, 1'b1);
        tick();
        drive(1'b1, 32'h00C00213, 32'h2008, 1'b1);
        tick();
        chk("third_pc", out_pc, 32'h2008);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        // Two illegal words, then reset while the second one is stalled
        drive(1'b1, 32'h00000000, 32'h3000, 1'b1);
        tick();
        drive(1'b1, 32'h00000000, 32'h3004, 1'b1);
        tick();
        chk("ill_flags", {illegal, rd_we, rs1_en, rs2_en}, 4'b1000);
        chk("ill_cnt_two", illegal_cnt, 3'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("no_reappear", out_valid, 1'b0);

        // Saturation of the illegal counter
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'hFFFF_FF7F, 32'h4000 + 32'(k * 4), 1'b1);
            tick();
        end
        chk("cnt_saturated", illegal_cnt, 3'd7);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        rst = 1'b0;

        // Random traffic with random back-pressure
        for (int k = 0; k < 80; k++) begin
            logic [31:0] r;
            r = $urandom();
            drive(1'($urandom_range(1, 0)), {r[31:7], ops[$urandom_range(12, 0)]},
                  $urandom(), 1'($urandom_range(3, 0) != 0));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
